// File: rtl/mp_register_file_if.sv
// Bus bundle between the decode-stage register file and its readers/writers.
// The master drives read addresses and both write ports; the slave returns read data and the dirty mask.
interface mp_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) ();
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister;
    logic [NUM_READ*DATA_WIDTH-1:0] ReadData;
    logic                           RegWrite0;
    logic [ADDR_WIDTH-1:0]          WriteRegister0;
    logic [DATA_WIDTH-1:0]          WriteData0;
    logic                           RegWrite1;
    logic [ADDR_WIDTH-1:0]          WriteRegister1;
    logic [DATA_WIDTH-1:0]          WriteData1;
    logic [NUM_REGS-1:0]            DirtyMask;

    modport master (
        output ReadRegister, RegWrite0, WriteRegister0, WriteData0,
               RegWrite1, WriteRegister1, WriteData1,
        input  ReadData, DirtyMask
    );

    modport slave (
        input  ReadRegister, RegWrite0, WriteRegister0, WriteData0,
               RegWrite1, WriteRegister1, WriteData1,
        output ReadData, DirtyMask
    );
endinterface

// File: rtl/mp_register_file.sv
// Multi-port register file: two write ports (port 1 wins on collision), N asynchronous read ports,
// optional write-to-read bypass, optional hardwired-zero register 0, and a sticky written-since-reset mask.
module mp_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input logic               Clk,
    input logic               Rst_n,
    mp_register_file_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    if (NUM_READ < 1 || NUM_READ > 8) begin : gNumReadCheck
        $error("mp_register_file: NUM_READ must be within 1..8");
    end

    logic [DATA_WIDTH-1:0]          regFile_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]          regFile_d [NUM_REGS];
    logic [NUM_REGS-1:0]            dirty_q;
    logic [NUM_REGS-1:0]            dirty_d;
    logic                           writeEn0;
    logic                           writeEn1;
    logic [ADDR_WIDTH-1:0]          rdAddr;
    logic [DATA_WIDTH-1:0]          rdValue;
    logic [NUM_READ*DATA_WIDTH-1:0] readBus;

    // A write aimed at a hardwired-zero register 0 is treated as if it was never enabled,
    // so it neither updates storage, nor sets the dirty bit, nor appears on the bypass path.
    always_comb begin
        writeEn0 = bus.RegWrite0 && !((ZERO_REG != 0) && (bus.WriteRegister0 == '0));
        writeEn1 = bus.RegWrite1 && !((ZERO_REG != 0) && (bus.WriteRegister1 == '0));
    end

    always_comb begin
        regFile_d = regFile_q;
        dirty_d   = dirty_q;
        if (writeEn0) begin
            regFile_d[bus.WriteRegister0] = bus.WriteData0;
            dirty_d[bus.WriteRegister0]   = 1'b1;
        end
        if (writeEn1) begin
            regFile_d[bus.WriteRegister1] = bus.WriteData1;
            dirty_d[bus.WriteRegister1]   = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regFile_q[r] <= '0;
            end
            dirty_q <= '0;
        end else begin
            regFile_q <= regFile_d;
            dirty_q   <= dirty_d;
        end
    end

    // Bypass is gated by Rst_n so every read port shows zero for the whole reset period.
    always_comb begin
        readBus = '0;
        rdAddr  = '0;
        rdValue = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rdAddr = bus.ReadRegister[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (!Rst_n) begin
                rdValue = '0;
            end else if ((ZERO_REG != 0) && (rdAddr == '0)) begin
                rdValue = '0;
            end else if ((BYPASS != 0) && writeEn1 && (bus.WriteRegister1 == rdAddr)) begin
                rdValue = bus.WriteData1;
            end else if ((BYPASS != 0) && writeEn0 && (bus.WriteRegister0 == rdAddr)) begin
                rdValue = bus.WriteData0;
            end else begin
                rdValue = regFile_q[rdAddr];
            end
            readBus[p*DATA_WIDTH +: DATA_WIDTH] = rdValue;
        end
    end

    assign bus.ReadData  = readBus;
    assign bus.DirtyMask = dirty_q;
endmodule

// File: tb/tb_mp_register_file.sv
// Self-checking bench: a bypassing/zero-reg 32-bit 2-read instance and a non-bypassing 16-bit 4-read
// instance with ordinary register 0 are driven with the same traffic and checked against array models.
module tb_mp_register_file;
    logic Clk = 1'b0;
    logic Rst_n;

    always #5 Clk = ~Clk;

    mp_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) busA ();
    mp_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_READ(4)) busB ();

    mp_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(1), .ZERO_REG(1))
        dutA (.Clk(Clk), .Rst_n(Rst_n), .bus(busA));
    mp_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_READ(4), .BYPASS(0), .ZERO_REG(0))
        dutB (.Clk(Clk), .Rst_n(Rst_n), .bus(busB));

    int total = 0;
    int bad   = 0;

    logic [31:0] mA [32];
    logic [15:0] mB [32];
    logic [31:0] dA;
    logic [31:0] dB;
    bit          inReset;

    bit          pWe0;
    bit          pWe1;
    logic [4:0]  pA0;
    logic [4:0]  pA1;
    logic [31:0] pD0;
    logic [31:0] pD1;
    logic [4:0]  ra [4];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearModels();
        for (int r = 0; r < 32; r++) begin
            mA[r] = '0;
            mB[r] = '0;
        end
        dA = '0;
        dB = '0;
    endtask

    // Instance A sees a same-cycle write immediately (port 1 first); register 0 always reads zero.
    function automatic logic [31:0] expA(input logic [4:0] addr);
        if (inReset || addr == 5'd0) return 32'h0;
        if (pWe1 && pA1 == addr) return pD1;
        if (pWe0 && pA0 == addr) return pD0;
        return mA[addr];
    endfunction

    // Writes land in program order, so port 1 naturally overrides port 0 on the same address.
    task automatic commitModel();
        if (pWe0) begin
            if (pA0 != 5'd0) begin
                mA[pA0] = pD0;
                dA[pA0] = 1'b1;
            end
            mB[pA0] = pD0[15:0];
            dB[pA0] = 1'b1;
        end
        if (pWe1) begin
            if (pA1 != 5'd0) begin
                mA[pA1] = pD1;
                dA[pA1] = 1'b1;
            end
            mB[pA1] = pD1[15:0];
            dB[pA1] = 1'b1;
        end
    endtask

    task automatic driveBus();
        busA.RegWrite0      = pWe0;
        busA.WriteRegister0 = pA0;
        busA.WriteData0     = pD0;
        busA.RegWrite1      = pWe1;
        busA.WriteRegister1 = pA1;
        busA.WriteData1     = pD1;
        busA.ReadRegister   = {ra[1], ra[0]};
        busB.RegWrite0      = pWe0;
        busB.WriteRegister0 = pA0;
        busB.WriteData0     = pD0[15:0];
        busB.RegWrite1      = pWe1;
        busB.WriteRegister1 = pA1;
        busB.WriteData1     = pD1[15:0];
        busB.ReadRegister   = {ra[3], ra[2], ra[1], ra[0]};
    endtask

    task automatic checkReads(input string phase);
        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("%s A.rd%0d r%0d", phase, p, ra[p]), busA.ReadData[p*32 +: 32], expA(ra[p]));
        end
        for (int p = 0; p < 4; p++) begin
            checkOutput($sformatf("%s B.rd%0d r%0d", phase, p, ra[p]), {16'h0, busB.ReadData[p*16 +: 16]},
                        inReset ? 32'h0 : {16'h0, mB[ra[p]]});
        end
        checkOutput({phase, " A.dirty"}, busA.DirtyMask, dA);
        checkOutput({phase, " B.dirty"}, busB.DirtyMask, dB);
    endtask

    // One write cycle: check reads before the edge (bypass window), then with writes off after the edge.
    task automatic applyStimulus(input bit we0, input int a0, input logic [31:0] d0,
                                 input bit we1, input int a1, input logic [31:0] d1,
                                 input int r0, input int r1, input int r2, input int r3);
        @(negedge Clk);
        pWe0 = we0; pA0 = 5'(a0); pD0 = d0;
        pWe1 = we1; pA1 = 5'(a1); pD1 = d1;
        ra[0] = 5'(r0); ra[1] = 5'(r1); ra[2] = 5'(r2); ra[3] = 5'(r3);
        driveBus();
        #1 checkReads("pre");
        @(posedge Clk);
        commitModel();
        #1;
        pWe0 = 1'b0;
        pWe1 = 1'b0;
        driveBus();
        #1 checkReads("post");
    endtask

    initial begin
        Rst_n   = 1'b0;
        inReset = 1'b1;
        pWe0 = 1'b1; pA0 = 5'd3; pD0 = 32'h1234_5678;
        pWe1 = 1'b0; pA1 = 5'd0; pD1 = 32'h0;
        ra[0] = 5'd3; ra[1] = 5'd0; ra[2] = 5'd3; ra[3] = 5'd31;
        clearModels();
        driveBus();
        #12 checkReads("reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        pWe0 = 1'b0;
        driveBus();
        Rst_n   = 1'b1;
        inReset = 1'b0;

        $display("[TB] basic write/read");
        applyStimulus(1, 8, 32'h77, 0, 0, 32'h0, 8, 9, 8, 9);

        $display("[TB] write collision");
        applyStimulus(1, 10, 32'hAAAA, 1, 10, 32'h5555, 10, 10, 10, 10);

        $display("[TB] register 0");
        applyStimulus(1, 0, 32'd77, 1, 0, 32'd77, 0, 0, 0, 0);

        $display("[TB] bypass");
        applyStimulus(1, 12, 32'd5, 0, 0, 32'h0, 12, 12, 12, 12);
        applyStimulus(1, 12, 32'd9, 0, 0, 32'h0, 12, 0, 12, 8);

        $display("[TB] multi-port sweep");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 1 + 2*k, 32'h0001_0000 + (1 + 2*k) * 37, 1, 2 + 2*k, 32'h00AB_0000 + (2 + 2*k) * 53,
                          1 + 2*k, 2 + 2*k, 0, 1);
        end
        for (int r = 1; r <= 18; r += 4) begin
            applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, r, r + 1, r + 2, r + 3);
        end

        $display("[TB] reset mid-operation");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 8 + 2*k, 32'(100 + 8 + 2*k), 1, 9 + 2*k, 32'(100 + 9 + 2*k), 8, 9, 10, 25);
        end
        @(negedge Clk);
        pWe0 = 1'b1; pA0 = 5'd8; pD0 = 32'hDEAD_BEEF;
        ra[0] = 5'd8; ra[1] = 5'd25; ra[2] = 5'd8; ra[3] = 5'd17;
        driveBus();
        #1;
        Rst_n   = 1'b0;
        inReset = 1'b1;
        clearModels();
        #1 checkReads("midreset");
        pWe0 = 1'b0;
        driveBus();
        #2;
        Rst_n   = 1'b1;
        inReset = 1'b0;
        for (int r = 8; r <= 25; r += 4) begin
            applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, r, r + 1, r + 2, (r + 3 > 25) ? 25 : r + 3);
        end

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            int a0;
            int a1;
            a0 = $urandom_range(0, 31);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
            applyStimulus(1'($urandom_range(0, 1)), a0, $urandom,
                          1'($urandom_range(0, 1)), a1, $urandom,
                          ($urandom_range(0, 1) == 0) ? a0 : $urandom_range(0, 31),
                          ($urandom_range(0, 1) == 0) ? a1 : $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 31));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mp_register_file.md
Name: mp_register_file

Overview:
- Parametrised successor to the single-write, two-read MIPS register file.
- Configurable data width, register count and read-port count.
- Adds a second write port with defined collision priority, optional same-cycle write-to-read bypass, and an asynchronous active-low clear of all registers.
- Exports a per-register written-since-reset mask for debug and verification.
- Sits in the decode stage, feeding operands to the ALU; the writeback stage and a secondary writeback path (e.g. HI/LO or load return) drive the two write ports.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..8).
- BYPASS, 1, when 1 a read of an address being written this cycle returns the new WriteData.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- Clk  input  1  system clock; all writes on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- ReadRegister  input  NUM_READ*ADDR_WIDTH  read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- ReadData  output  NUM_READ*DATA_WIDTH  read data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- RegWrite0  input  1  write enable, port 0.
- WriteRegister0  input  ADDR_WIDTH  write address, port 0.
- WriteData0  input  DATA_WIDTH  write data, port 0.
- RegWrite1  input  1  write enable, port 1.
- WriteRegister1  input  ADDR_WIDTH  write address, port 1.
- WriteData1  input  DATA_WIDTH  write data, port 1.
- DirtyMask  output  NUM_REGS  bit r = 1 once register r has been written since reset.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous, active-low (Rst_n).
- Reset (Rst_n=0):
  - All registers clear to 0 immediately, without waiting for Clk.
  - DirtyMask clears to 0.
  - All ReadData read 0 for the whole reset period, because bypass is gated off by Rst_n.
  - Writes are ignored while Rst_n=0.
- Reset release: registers start accepting writes at the first rising Clk edge where Rst_n=1. Deassertion close to an edge may drop that edge's write; this is accepted.
- Reads:
  - Combinational and asynchronous; zero-cycle latency from address to data.
  - Any number of ports may read the same address.
- Writes:
  - On rising Clk, if RegWriteN=1, register[WriteRegisterN] <= WriteDataN.
  - The written value is visible at ReadData after the edge: 0 cycles later when BYPASS=1, after the edge when BYPASS=0.
- Write collision: both ports enabled with the same address → port 1 wins; the port 0 data is discarded.
- Register 0 with ZERO_REG=1:
  - Writes to register 0 are discarded.
  - Reads of register 0 always return 0, including via bypass.
  - DirtyMask[0] stays 0.
- Register 0 with ZERO_REG=0: register 0 behaves like any other register.
- Bypass (BYPASS=1, Rst_n=1):
  - If ReadRegister_i matches an enabled write address, ReadData_i = that write data (port 1 priority on collision) instead of the stored value.
  - The path is purely combinational from WriteData/RegWrite/WriteRegister to ReadData.
- DirtyMask:
  - Bit r sets on the rising edge that commits a write to r.
  - Bits are sticky until reset; writing an identical value still sets the bit.
- Reset mid-operation: Rst_n falling in the middle of a cycle with writes pending → no write commits, registers clear, ReadData go to 0 asynchronously.
- Invalid parameters: NUM_READ outside 1..8 is illegal; the RTL must fail elaboration.

Test Plan:
- Reset: load regs 8..25 with 100+r, pulse Rst_n low for 3ns mid-cycle → all ReadData=0 at once; DirtyMask=0; reads of 8..25 return 0 after release.
- Basic write/read: write r8=0x77 via port 0, read ports 0/1 on r8/r9 → ReadData0=0x77, ReadData1=0; DirtyMask[8]=1, DirtyMask[9]=0.
- Collision: same cycle, port 0 r10=0xAAAA and port 1 r10=0x5555 → after the edge r10 reads 0x5555; with BYPASS=1 it also reads 0x5555 before the edge.
- Register 0: write r0=77 (decimal) on both ports → reads of r0 return 0, DirtyMask[0]=0; repeat with ZERO_REG=0 → r0 reads 77.
- Bypass: BYPASS=1, r12 holds 5, write r12=9 and read r12 in the same cycle → ReadData shows 9 before the edge; with BYPASS=0 it shows 5 until after the edge, then 9.
- Multi-port sweep: NUM_READ=4, DATA_WIDTH=16, write 18 distinct values across both ports, then read 4 at a time → every port matches a reference model; random simultaneous writes checked against the port-1-priority rule.
